// File: rtl/product_accumulator.sv
// product_accumulator
//  Sums a programmed number of unsigned products from the shift-add multiplier
//  into an AW-bit accumulator. Products arrive on a valid/ready handshake and
//  the final sum leaves on a second one.
//  Optional feature macro: ACC_SAT_EN. When it is defined, the accumulator
//  saturates at all-ones on carry out. When it is undefined, the accumulator
//  wraps modulo 2^AW. In both builds the sticky overflow flag is set.
//  AW must be at least PW.
module product_accumulator #(
    parameter int PW = 32,
    parameter int AW = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    len,
    input  logic          prod_valid,
    output logic          prod_ready,
    input  logic [PW-1:0] product,
    output logic          sum_valid,
    input  logic          sum_ready,
    output logic [AW-1:0] sum,
    output logic          overflow,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_reg;
    logic [AW-1:0] acc_reg;
    logic [7:0]    cnt_reg;
    logic          ovf_reg;

    // One extra bit on the adder so the carry out of AW bits is visible.
    logic [AW:0]   add_full;
    logic          add_carry;
    logic [AW-1:0] acc_next;

    // Zero-extend the product and add it to the running sum.
    always_comb begin
        add_full  = {1'b0, acc_reg} + {{(AW + 1 - PW){1'b0}}, product};
        add_carry = add_full[AW];
`ifdef ACC_SAT_EN
        // Clamp to all-ones on carry. Once at all-ones, any non-zero add
        // carries again, so the value stays pinned there.
        acc_next  = add_carry ? {AW{1'b1}} : add_full[AW-1:0];
`else
        acc_next  = add_full[AW-1:0];
`endif
    end

    // Sequence control: IDLE -> ACCUM -> DONE -> IDLE, with the running sum and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        acc_reg <= '0;
                        ovf_reg <= 1'b0;
                        cnt_reg <= len;
                        // A zero-length sequence has nothing to add and
                        // presents sum=0 straight away.
                        state_reg <= (len == 8'd0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (prod_valid) begin
                        acc_reg <= acc_next;
                        cnt_reg <= cnt_reg - 8'd1;
                        if (add_carry) begin
                            ovf_reg <= 1'b1;
                        end
                        if (cnt_reg == 8'd1) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    // start is ignored here, even together with sum_ready.
                    // The sum and flag stay visible until the next start.
                    if (sum_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Handshake and status outputs decode directly from the state register.
    always_comb begin
        prod_ready = (state_reg == ACCUM);
        sum_valid  = (state_reg == DONE);
        busy       = (state_reg != IDLE);
        sum        = acc_reg;
        overflow   = ovf_reg;
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
//  Random and directed sequences for product_accumulator. The expected result
//  of each sequence is the plain arithmetic sum of its products, reduced to AW
//  bits (wrap) or clamped (ACC_SAT_EN). The expected result is queued when the
//  sequence is issued. A monitor pops the queue on every sum handshake.
module tb_product_accumulator;

    localparam int PW = 32;
    localparam int AW = 34;
    localparam longint unsigned ACC_MAX = (64'd1 << AW) - 64'd1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [7:0]    len;
    logic          prod_valid;
    logic          prod_ready;
    logic [PW-1:0] product;
    logic          sum_valid;
    logic          sum_ready;
    logic [AW-1:0] sum;
    logic          overflow;
    logic          busy;

    product_accumulator #(.PW(PW), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .product    (product),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .sum        (sum),
        .overflow   (overflow),
        .busy       (busy)
    );

    typedef struct {
        longint unsigned sum;
        bit              ovf;
        int              len;
    } exp_t;

    exp_t          exp_q[$];
    logic [PW-1:0] stim_prods [0:255];
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            pat [7] = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected summary before it");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_prod_ready"}, 64'(prod_ready), 0);
        check({tag, "_sum_valid"},  64'(sum_valid),  0);
        check({tag, "_sum"},        64'(sum),        0);
        check({tag, "_overflow"},   64'(overflow),   0);
        check({tag, "_busy"},       64'(busy),       0);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin : monitor
        int              xfer = 0;
        bit              after_hs = 0;
        bit              expect_valid = 0;
        longint unsigned hs_sum = 0;
        bit              hs_ovf = 0;
        exp_t            e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                xfer = 0;
                exp_q.delete();
                after_hs = 0;
                expect_valid = 0;
            end else begin
                if (after_hs) begin
                    check("idle_after_take", 64'(sum_valid), 0);
                    check("busy_after_take", 64'(busy), 0);
                    check("sum_kept",        64'(sum), hs_sum);
                    check("ovf_kept",        64'(overflow), 64'(hs_ovf));
                    after_hs = 0;
                end
                if (expect_valid) begin
                    check("latency_sum_valid", 64'(sum_valid), 1);
                    expect_valid = 0;
                end
                if (prod_valid && prod_ready) begin
                    xfer++;
                    if (exp_q.size() > 0 && xfer == exp_q[0].len) expect_valid = 1;
                end
                if (sum_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_sum: got sum_valid=1 with sum 0x%0h, expected no pending result", sum);
                    end else if (sum_ready) begin
                        e = exp_q.pop_front();
                        check("sum",       64'(sum), e.sum);
                        check("overflow",  64'(overflow), 64'(e.ovf));
                        check("transfers", 64'(xfer), 64'(e.len));
                        $display("seq len=%0d sum=0x%0h ovf=%0d (expected 0x%0h ovf=%0d)",
                                 e.len, sum, overflow, e.sum, e.ovf);
                        xfer = 0;
                        after_hs = 1;
                        hs_sum = e.sum;
                        hs_ovf = e.ovf;
                    end else begin
                        check("sum_hold",   64'(sum), exp_q[0].sum);
                        check("busy_done",  64'(busy), 1);
                    end
                end
            end
        end
    end

    // Issue one sequence of n products from stim_prods.
    //  gap_pct  < 0 uses the fixed valid pattern, else % of idle cycles
    //  hold     cycles with sum_ready low once the products are in
    //  abort_at >= 0 pulses reset after that many transfers
    task automatic run_seq(input int n, input int gap_pct, input int hold, input int abort_at);
        longint unsigned total;
        exp_t            e;
        int              idx;
        int              cyc;
        bit              took;
        total = 0;
        for (int i = 0; i < n; i++) total += 64'(stim_prods[i]);
        e.len = n;
        e.ovf = (total > ACC_MAX);
`ifdef ACC_SAT_EN
        e.sum = e.ovf ? ACC_MAX : total;
`else
        e.sum = total & ACC_MAX;
`endif
        if (abort_at < 0) exp_q.push_back(e);

        start = 1'b1;
        len   = n[7:0];
        @(posedge clk); #1;
        start = 1'b0;

        if (n == 0) begin
            prod_valid = 1'b1;
            @(negedge clk);
            check("len0_sum_valid",  64'(sum_valid), 1);
            check("len0_prod_ready", 64'(prod_ready), 0);
            @(posedge clk); #1;
        end

        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 2000) begin
            if (abort_at >= 0 && idx == abort_at) begin
                prod_valid = 1'b0;
                start = 1'b0;
                rst_n = 1'b0;
                #1;
                check_all_zero("abort_reset");
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(negedge clk);
                check_all_zero("after_abort");
                @(posedge clk); #1;
                return;
            end
            prod_valid = (gap_pct < 0) ? pat[cyc % 7] : ($urandom_range(99) >= gap_pct);
            product = stim_prods[idx];
            // start with a bogus length must be ignored mid-sequence
            start = ($urandom_range(3) == 0);
            len = 8'($urandom);
            @(negedge clk);
            took = prod_valid && prod_ready;
            @(posedge clk); #1;
            if (took) idx++;
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL product_accept_timeout: got %0d transfers, expected %0d", idx, n);
        end
        prod_valid = (n == 0);
        product = $urandom;

        repeat (hold) begin
            @(posedge clk); #1;
        end
        sum_ready = 1'b1;
        start = 1'b1;
        len = 8'd3;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sum_handshake_timeout: got %0d pending results, expected 0", exp_q.size());
            exp_q.delete();
        end
        sum_ready = 1'b0;
        start = 1'b0;
        prod_valid = 1'b0;
    endtask

    initial begin : stimulus
        int n;
        rst_n = 1'b1;
        start = 1'b0;
        len = 8'd0;
        prod_valid = 1'b0;
        product = '0;
        sum_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");
        @(posedge clk); #1;

        // back-to-back 20+30+50
        stim_prods[0] = 20; stim_prods[1] = 30; stim_prods[2] = 50;
        run_seq(3, 0, 0, -1);
        // zero length
        run_seq(0, 0, 2, -1);
        // consumer stalls for 5 cycles
        stim_prods[0] = 32'h14; stim_prods[1] = 32'h0A;
        run_seq(2, 0, 5, -1);
        // carry out of 34 bits
        for (int i = 0; i < 5; i++) stim_prods[i] = 32'hFFFF_FFFF;
        run_seq(5, 0, 1, -1);
        // valid toggling 1,0,0,1,1,0,1
        for (int i = 0; i < 4; i++) stim_prods[i] = 32'(i + 1);
        run_seq(4, -1, 0, -1);
        // reset after 2 of 4, then a fresh single product
        run_seq(4, 0, 0, 2);
        stim_prods[0] = 7;
        run_seq(1, 0, 0, -1);

        // randomized sequences
        for (int s = 0; s < 40; s++) begin
            n = $urandom_range(12);
            for (int i = 0; i < n; i++)
                stim_prods[i] = ($urandom_range(2) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(255))) : 32'($urandom);
            run_seq(n, $urandom_range(50), $urandom_range(3), -1);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
